// File: rtl/axi_rd_arbiter.sv
// Two-port (I-cache / D-cache) AXI read arbiter with one outstanding transaction.
// Data has priority; a 2-bit streak counter guards the instruction port against starvation.
module axi_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_rlast,
    output logic              i_rerr,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [7:0]        d_len,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rlast,
    output logic              d_rerr,

    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,

    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    localparam int unsigned STREAK_W = 2;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(3);
    localparam logic [3:0] ID_INSTR = 4'd0;
    localparam logic [3:0] ID_DATA  = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 owner_d_q;
    logic [STREAK_W-1:0]  streak_q;
    logic                 start_c;
    logic                 sel_data_c;

    // Routing is driven by the registered owner, so the returned ID is irrelevant.
    logic unused_rid;
    assign unused_rid = ^rid;

    assign arsize  = 3'b010;
    assign arburst = 2'b01;

    assign start_c    = (state_q == ST_IDLE) && (i_req || d_req);
    assign sel_data_c = d_req && !(i_req && (streak_q == STREAK_MAX));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rvalid && rlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant pulse and zero-latency beat forwarding to the current owner only.
    always_comb begin
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        i_rerr   = 1'b0;
        d_rvalid = 1'b0;
        d_rlast  = 1'b0;
        d_rerr   = 1'b0;
        i_rdata  = rdata;
        d_rdata  = rdata;
        if (resetn) begin
            case (state_q)
                ST_ADDR: begin
                    if (arready) begin
                        if (owner_d_q) begin
                            d_gnt = 1'b1;
                        end else begin
                            i_gnt = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (owner_d_q) begin
                        d_rvalid = rvalid;
                        d_rlast  = rvalid && rlast;
                        d_rerr   = rvalid && (rresp != 2'b00);
                    end else begin
                        i_rvalid = rvalid;
                        i_rlast  = rvalid && rlast;
                        i_rerr   = rvalid && (rresp != 2'b00);
                    end
                end
                default: ;
            endcase
        end
    end

    // Request capture, owner/streak bookkeeping and registered AXI control.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner_d_q <= 1'b0;
            streak_q  <= '0;
            araddr    <= '0;
            arlen     <= '0;
            arid      <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
        end else begin
            arvalid <= (state_d == ST_ADDR);
            rready  <= (state_d == ST_DATA);
            if (start_c) begin
                owner_d_q <= sel_data_c;
                if (sel_data_c) begin
                    araddr <= d_addr;
                    arlen  <= d_len;
                    arid   <= ID_DATA;
                    if (i_req && (streak_q != STREAK_MAX)) begin
                        streak_q <= streak_q + STREAK_W'(1);
                    end
                end else begin
                    araddr   <= i_addr;
                    arlen    <= i_len;
                    arid     <= ID_INSTR;
                    streak_q <= '0;
                end
            end
        end
    end

endmodule
